antares_mem_arbiter: RTL and testbench
======================================

// Module: antares_mem_arbiter
// PURPOSE
//  Shares one single-port memory/bus slave between the core instruction port (iport) and data port
//  (dport). Sits between antares_core and a single-port memory, replacing the dual-port memory.
//  Arbitrates, registers the winning request, forwards it to the slave, routes ready/error back.
//  Also enforces a response timeout.
// PARAMETERS
//  RR_ENABLE       1     1 = round-robin on simultaneous requests; 0 = fixed priority, dport wins
//  TIMEOUT_CYCLES  1024  max busy cycles before the arbiter aborts with error; 0 = timeout disabled
// PORTS
//  clk             in   1   single clock
//  rst             in   1   synchronous, active-high reset
//  iport_address   in   32  instruction request address
//  iport_data_i    in   32  instruction write data (normally unused)
//  iport_wr        in   4   instruction byte write enables (0 = read)
//  iport_enable    in   1   instruction request
//  iport_data_o    out  32  read data to instruction port (= mem_data_i)
//  iport_ready     out  1   instruction transaction done
//  iport_error     out  1   instruction transaction failed (slave error or timeout)
//  dport_address   in   32  data request address
//  dport_data_i    in   32  data write data
//  dport_wr        in   4   data byte write enables (0 = read)
//  dport_enable    in   1   data request
//  dport_data_o    out  32  read data to data port (= mem_data_i)
//  dport_ready     out  1   data transaction done
//  dport_error     out  1   data transaction failed
//  mem_address     out  32  registered slave address
//  mem_data_o      out  32  registered slave write data
//  mem_wr          out  4   registered slave byte enables
//  mem_enable      out  1   registered slave request
//  mem_data_i      in   32  slave read data
//  mem_ready       in   1   slave done
//  mem_error       in   1   slave error
// BEHAVIOUR
//  - FSM states: IDLE, BUSY_I, BUSY_D. Reset: IDLE; mem_enable/address/data_o/wr = 0.
//  - Reset: timeout counter = 0; RR pointer last_grant = iport. All ready/error outputs 0.
//  - IDLE: sample iport_enable/dport_enable. At the clock edge, latch the winner's
//    address/data/wr into mem_* and set mem_enable = 1. Move to BUSY_I/BUSY_D.
//    No request: stay in IDLE.
//  - Tie, RR_ENABLE=1: grant the port not in last_grant; last_grant updates on every grant.
//  - Tie, RR_ENABLE=0: dport always wins; iport can starve by design.
//  - BUSY_x: mem_* held constant; master enable/address ignored (request already latched).
//    A master dropping enable does not abort the transaction.
//  - Completion in BUSY_x on mem_ready | mem_error | timeout_hit:
//    x_ready = mem_ready, x_error = mem_error | timeout_hit (combinational, same cycle).
//    At the edge: IDLE, mem_enable <= 0, counter <= 0.
//  - Non-granted port's ready/error are always 0. data_o to both ports = mem_data_i.
//  - mem_ready and mem_error both high: both forwarded; transaction ends.
//  - Timeout: counter increments each BUSY cycle without completion.
//    timeout_hit = (TIMEOUT_CYCLES != 0) && counter == TIMEOUT_CYCLES-1 && !mem_ready && !mem_error.
//    Fires in the TIMEOUT_CYCLES-th busy cycle. mem_ready in that cycle takes precedence.
//  - Latency: request at cycle t -> mem_enable at t+1. Slave ready at u -> master ready at u.
//    Next grant no earlier than u+1 (mem_enable low >= 1 cycle between transactions).
//  - Protocol: a master enable seen in the cycle after its ready is a new request.
//  - rst mid-transaction: IDLE next cycle, mem_enable = 0; no ready/error issued for the aborted request.
// TESTING
//  1. iport read addr 0x100, slave ready 2 cycles after mem_enable with 0xDEADBEEF:
//     -> mem_address=0x100, mem_wr=0 at t+1; iport_ready=1, iport_data_o=0xDEADBEEF; dport_ready=0.
//  2. RR_ENABLE=1, both request continuously after reset -> grants D, I, D, I;
//     mem_enable low 1 cycle between each grant.
//  3. RR_ENABLE=0, both request continuously -> only dport granted; iport_ready stays 0.
//  4. dport write addr 0x204, wr=4'b0011, data 0x12345678; master drops enable the cycle after grant
//     -> mem_* hold these values until mem_ready; dport_ready pulses once.
//  5. TIMEOUT_CYCLES=8, slave never ready -> dport_error=1 in 8th busy cycle only;
//     mem_enable=0 next cycle; pending iport then served normally.
//  6. rst asserted in BUSY_I -> mem_enable=0 next cycle, iport_ready/error never pulse;
//     first tie afterwards grants dport.

Source files
------------

// File: rtl/antares_mem_arbiter.sv
// ============================================================================
//  Module      : antares_mem_arbiter
//  Description : Shares one single-port memory / bus slave between the core
//                instruction port (iport) and data port (dport). The winning
//                request is registered onto the slave interface and held for
//                the whole transaction. Ready and error are routed back to the
//                granted master in the same cycle the slave answers. A busy
//                watchdog aborts a transaction that the slave never completes.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RR_ENABLE       1 = round-robin on simultaneous requests,
//                    0 = fixed priority (dport always wins a tie)
//    TIMEOUT_CYCLES  busy cycles allowed before aborting with error
//                    (0 disables the watchdog)
//  Ports
//    clk, rst                 clock, synchronous active-high reset
//    iport_address/data_i/wr/enable   instruction master request
//    iport_data_o/ready/error         instruction master response
//    dport_address/data_i/wr/enable   data master request
//    dport_data_o/ready/error         data master response
//    mem_address/data_o/wr/enable     registered slave request
//    mem_data_i/ready/error           slave response
// ============================================================================
`default_nettype none

module antares_mem_arbiter #(
    parameter int RR_ENABLE      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,

    // Instruction master
    input  logic [31:0] iport_address,
    input  logic [31:0] iport_data_i,
    input  logic [3:0]  iport_wr,
    input  logic        iport_enable,
    output logic [31:0] iport_data_o,
    output logic        iport_ready,
    output logic        iport_error,

    // Data master
    input  logic [31:0] dport_address,
    input  logic [31:0] dport_data_i,
    input  logic [3:0]  dport_wr,
    input  logic        dport_enable,
    output logic [31:0] dport_data_o,
    output logic        dport_ready,
    output logic        dport_error,

    // Shared slave
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_wr,
    output logic        mem_enable,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ready,
    input  logic        mem_error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits suffice.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic c_TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic c_RR_EN = (RR_ENABLE != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [31:0]        r_mem_address;
    logic [31:0]        r_mem_data_o;
    logic [3:0]         r_mem_wr;
    logic               r_mem_enable;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last_d;      // 1 = last grant went to dport

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic w_busy;
    logic w_busy_i;
    logic w_busy_d;
    logic w_timeout_hit;
    logic w_done;
    logic w_grant_d;
    logic w_grant_i;

    assign w_busy   = (r_state != S_IDLE);
    assign w_busy_i = (r_state == S_BUSY_I);
    assign w_busy_d = (r_state == S_BUSY_D);

    // A slave answer in the last allowed cycle wins over the watchdog.
    assign w_timeout_hit = c_TO_EN && w_busy && (r_cnt == c_CNT_LAST)
                           && !mem_ready && !mem_error;

    assign w_done = w_busy && (mem_ready || mem_error || w_timeout_hit);

    // dport wins unless iport is also asking and round-robin says it is
    // iport's turn (dport took the previous grant).
    assign w_grant_d = dport_enable && (!iport_enable || !c_RR_EN || !r_last_d);
    assign w_grant_i = iport_enable && !w_grant_d;

    // ------------------------------------------------------------------------
    // Arbitration FSM with registered slave request
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mem_address <= '0;
            r_mem_data_o  <= '0;
            r_mem_wr      <= '0;
            r_mem_enable  <= 1'b0;
            r_cnt         <= '0;
            r_last_d      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_d) begin
                        r_mem_address <= dport_address;
                        r_mem_data_o  <= dport_data_i;
                        r_mem_wr      <= dport_wr;
                        r_mem_enable  <= 1'b1;
                        r_last_d      <= 1'b1;
                        r_state       <= S_BUSY_D;
                    end else if (w_grant_i) begin
                        r_mem_address <= iport_address;
                        r_mem_data_o  <= iport_data_i;
                        r_mem_wr      <= iport_wr;
                        r_mem_enable  <= 1'b1;
                        r_last_d      <= 1'b0;
                        r_state       <= S_BUSY_I;
                    end
                end

                S_BUSY_I, S_BUSY_D: begin
                    // Request fields stay frozen; masters are ignored here.
                    if (w_done) begin
                        r_mem_enable <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                default: begin
                    r_mem_enable <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_address  = r_mem_address;
    assign mem_data_o   = r_mem_data_o;
    assign mem_wr       = r_mem_wr;
    assign mem_enable   = r_mem_enable;

    // Read data is broadcast; only the granted port sees ready/error.
    assign iport_data_o = mem_data_i;
    assign dport_data_o = mem_data_i;

    assign iport_ready  = w_busy_i && mem_ready;
    assign iport_error  = w_busy_i && (mem_error || w_timeout_hit);
    assign dport_ready  = w_busy_d && mem_ready;
    assign dport_error  = w_busy_d && (mem_error || w_timeout_hit);

endmodule

`default_nettype wire

// File: tb/tb_antares_mem_arbiter.sv
// ============================================================================
//  Module      : tb_antares_mem_arbiter
//  Description : Directed bench for antares_mem_arbiter. A round-robin
//                instance (TIMEOUT_CYCLES=8) runs a per-cycle vector table and
//                hand-written timeout / reset sequences; a fixed-priority
//                instance is exercised for dport dominance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_antares_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] iport_address = '0;
    logic [31:0] iport_data_i  = '0;
    logic [3:0]  iport_wr      = '0;
    logic        iport_enable  = 1'b0;
    logic [31:0] dport_address = '0;
    logic [31:0] dport_data_i  = '0;
    logic [3:0]  dport_wr      = '0;
    logic        dport_enable  = 1'b0;
    logic [31:0] mem_data_i    = '0;
    logic        mem_ready     = 1'b0;
    logic        mem_error     = 1'b0;
    logic        fp_mem_ready  = 1'b0;
    logic        fp_mem_error  = 1'b0;

    logic [31:0] iport_data_o, dport_data_o, mem_address, mem_data_o;
    logic        iport_ready, iport_error, dport_ready, dport_error, mem_enable;
    logic [3:0]  mem_wr;

    logic [31:0] fp_iport_data_o, fp_dport_data_o, fp_mem_address, fp_mem_data_o;
    logic        fp_iport_ready, fp_iport_error, fp_dport_ready, fp_dport_error;
    logic        fp_mem_enable;
    logic [3:0]  fp_mem_wr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    antares_mem_arbiter #(.RR_ENABLE(1), .TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .rst(rst),
        .iport_address(iport_address), .iport_data_i(iport_data_i),
        .iport_wr(iport_wr), .iport_enable(iport_enable),
        .iport_data_o(iport_data_o), .iport_ready(iport_ready), .iport_error(iport_error),
        .dport_address(dport_address), .dport_data_i(dport_data_i),
        .dport_wr(dport_wr), .dport_enable(dport_enable),
        .dport_data_o(dport_data_o), .dport_ready(dport_ready), .dport_error(dport_error),
        .mem_address(mem_address), .mem_data_o(mem_data_o), .mem_wr(mem_wr),
        .mem_enable(mem_enable), .mem_data_i(mem_data_i),
        .mem_ready(mem_ready), .mem_error(mem_error)
    );

    antares_mem_arbiter #(.RR_ENABLE(0), .TIMEOUT_CYCLES(8)) u_dut_fp (
        .clk(clk), .rst(rst),
        .iport_address(iport_address), .iport_data_i(iport_data_i),
        .iport_wr(iport_wr), .iport_enable(iport_enable),
        .iport_data_o(fp_iport_data_o), .iport_ready(fp_iport_ready), .iport_error(fp_iport_error),
        .dport_address(dport_address), .dport_data_i(dport_data_i),
        .dport_wr(dport_wr), .dport_enable(dport_enable),
        .dport_data_o(fp_dport_data_o), .dport_ready(fp_dport_ready), .dport_error(fp_dport_error),
        .mem_address(fp_mem_address), .mem_data_o(fp_mem_data_o), .mem_wr(fp_mem_wr),
        .mem_enable(fp_mem_enable), .mem_data_i(mem_data_i),
        .mem_ready(fp_mem_ready), .mem_error(fp_mem_error)
    );

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        ien;
        logic [31:0] ia;
        logic        den;
        logic [31:0] da;
        logic [3:0]  dw;
        logic [31:0] dd;
        logic        mr;
        logic        me;
        logic [31:0] md;
        logic        e_men;
        logic [31:0] e_ma;
        logic [31:0] e_md;
        logic [3:0]  e_mw;
        logic        e_ir;
        logic        e_ie;
        logic        e_dr;
        logic        e_de;
    } vec_t;

    function automatic vec_t v(
        input logic rst_i, input logic ien, input logic [31:0] ia,
        input logic den, input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd,
        input logic mr, input logic me, input logic [31:0] md,
        input logic e_men, input logic [31:0] e_ma, input logic [31:0] e_md, input logic [3:0] e_mw,
        input logic e_ir, input logic e_ie, input logic e_dr, input logic e_de);
        vec_t r;
        r.rst = rst_i; r.ien = ien; r.ia = ia; r.den = den; r.da = da; r.dw = dw; r.dd = dd;
        r.mr = mr; r.me = me; r.md = md; r.e_men = e_men; r.e_ma = e_ma; r.e_md = e_md;
        r.e_mw = e_mw; r.e_ir = e_ir; r.e_ie = e_ie; r.e_dr = e_dr; r.e_de = e_de;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change 2 time units after the active edge; outputs are read 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        rst = 1'b0; iport_enable = 1'b0; dport_enable = 1'b0;
        iport_address = '0; dport_address = '0; dport_wr = '0; dport_data_i = '0;
        mem_ready = 1'b0; mem_error = 1'b0; mem_data_i = '0;
    endtask

    vec_t tbl[$];
    int   fp_dr_cnt;

    initial begin
        // --- Test 1: iport read, slave ready 2 cycles after mem_enable
        tbl.push_back(v(0, 0,0,          0,0,0,0,              0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 1,32'h100,    0,0,0,0,              0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 0,32'h100,    0,0,0,0,              0,0,0,           1,32'h100,0,0,                  0,0,0,0));
        tbl.push_back(v(0, 0,32'h100,    0,0,0,0,              0,0,0,           1,32'h100,0,0,                  0,0,0,0));
        tbl.push_back(v(0, 0,32'h100,    0,0,0,0,              1,0,32'hDEADBEEF,1,32'h100,0,0,                  1,0,0,0));
        tbl.push_back(v(0, 0,0,          0,0,0,0,              0,0,0,           0,0,0,0,                        0,0,0,0));
        // --- Test 4: dport write, master drops enable after grant
        tbl.push_back(v(0, 0,0,          1,32'h204,4'b0011,32'h12345678, 0,0,0, 0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 0,0,          0,32'hFFFF0000,4'hF,32'hCAFEF00D, 0,0,0, 1,32'h204,32'h12345678,4'b0011, 0,0,0,0));
        tbl.push_back(v(0, 0,0,          0,32'hFFFF0000,4'hF,32'hCAFEF00D, 0,0,0, 1,32'h204,32'h12345678,4'b0011, 0,0,0,0));
        tbl.push_back(v(0, 0,0,          0,0,0,0,              1,0,32'h55AA55AA,1,32'h204,32'h12345678,4'b0011, 0,0,1,0));
        tbl.push_back(v(0, 0,0,          0,0,0,0,              0,0,0,           0,0,0,0,                        0,0,0,0));
        // --- Test 2: reset, then both request continuously: D, I, D, I
        tbl.push_back(v(1, 0,0,          0,0,0,0,              0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         1,0,32'h1111,    1,32'hB0,0,0,                   0,0,1,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         1,0,32'h2222,    1,32'hA0,0,0,                   1,0,0,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         1,0,32'h3333,    1,32'hB0,0,0,                   0,0,1,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 1,32'hA0,     1,32'hB0,0,0,         1,0,32'h4444,    1,32'hA0,0,0,                   1,0,0,0));
        tbl.push_back(v(0, 0,0,          0,0,0,0,              0,0,0,           0,0,0,0,                        0,0,0,0));
        // --- Slave ready and error together: both forwarded
        tbl.push_back(v(0, 0,0,          1,32'h300,0,0,        0,0,0,           0,0,0,0,                        0,0,0,0));
        tbl.push_back(v(0, 0,0,          0,0,0,0,              1,1,32'h5555,    1,32'h300,0,0,                  0,0,1,1));
        tbl.push_back(v(0, 0,0,          0,0,0,0,              0,0,0,           0,0,0,0,                        0,0,0,0));

        // Reset for two cycles
        rst = 1'b1;
        @(posedge clk);
        next_cycle();

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            iport_enable = tbl[i].ien; iport_address = tbl[i].ia;
            dport_enable = tbl[i].den; dport_address = tbl[i].da;
            dport_wr = tbl[i].dw; dport_data_i = tbl[i].dd;
            mem_ready = tbl[i].mr; mem_error = tbl[i].me; mem_data_i = tbl[i].md;
            #1;
            chk($sformatf("v%0d mem_enable", i), {31'd0, mem_enable}, {31'd0, tbl[i].e_men});
            if (tbl[i].e_men) begin
                chk($sformatf("v%0d mem_address", i), mem_address, tbl[i].e_ma);
                chk($sformatf("v%0d mem_data_o", i), mem_data_o, tbl[i].e_md);
                chk($sformatf("v%0d mem_wr", i), {28'd0, mem_wr}, {28'd0, tbl[i].e_mw});
            end
            chk($sformatf("v%0d iport_ready", i), {31'd0, iport_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("v%0d iport_error", i), {31'd0, iport_error}, {31'd0, tbl[i].e_ie});
            chk($sformatf("v%0d dport_ready", i), {31'd0, dport_ready}, {31'd0, tbl[i].e_dr});
            chk($sformatf("v%0d dport_error", i), {31'd0, dport_error}, {31'd0, tbl[i].e_de});
            if (tbl[i].e_ir) chk($sformatf("v%0d iport_data_o", i), iport_data_o, tbl[i].md);
            if (tbl[i].e_dr) chk($sformatf("v%0d dport_data_o", i), dport_data_o, tbl[i].md);
            next_cycle();
        end

        // --- Test 5: timeout on dport in the 8th busy cycle, pending iport served after
        drive_idle();
        dport_enable = 1'b1; dport_address = 32'h400;
        #1;
        chk("to grant idle mem_enable", {31'd0, mem_enable}, 32'd0);
        next_cycle();
        dport_enable = 1'b0; iport_enable = 1'b1; iport_address = 32'h480;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("to busy%0d mem_enable", k), {31'd0, mem_enable}, 32'd1);
            chk($sformatf("to busy%0d mem_address", k), mem_address, 32'h400);
            chk($sformatf("to busy%0d dport_error", k), {31'd0, dport_error}, (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("to busy%0d dport_ready", k), {31'd0, dport_ready}, 32'd0);
            chk($sformatf("to busy%0d iport_error", k), {31'd0, iport_error}, 32'd0);
            next_cycle();
        end
        #1;
        chk("to after mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("to after dport_error", {31'd0, dport_error}, 32'd0);
        next_cycle();
        iport_enable = 1'b0; mem_ready = 1'b1; mem_data_i = 32'hA5A5A5A5;
        #1;
        chk("to iport mem_address", mem_address, 32'h480);
        chk("to iport ready", {31'd0, iport_ready}, 32'd1);
        chk("to iport error", {31'd0, iport_error}, 32'd0);
        chk("to iport data", iport_data_o, 32'hA5A5A5A5);
        next_cycle();

        // --- Slave ready in the 8th busy cycle beats the watchdog
        drive_idle();
        dport_enable = 1'b1; dport_address = 32'h440;
        next_cycle();
        dport_enable = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            mem_ready = (k == 8);
            #1;
            chk($sformatf("prec busy%0d dport_error", k), {31'd0, dport_error}, 32'd0);
            chk($sformatf("prec busy%0d dport_ready", k), {31'd0, dport_ready}, (k == 8) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drive_idle();
        #1;
        chk("prec after mem_enable", {31'd0, mem_enable}, 32'd0);
        next_cycle();

        // --- Test 6: reset in BUSY_I aborts silently; next tie goes to dport
        iport_enable = 1'b1; iport_address = 32'h500;
        next_cycle();
        iport_enable = 1'b0; rst = 1'b1;
        #1;
        chk("rst busy mem_enable", {31'd0, mem_enable}, 32'd1);
        chk("rst busy mem_address", mem_address, 32'h500);
        chk("rst busy iport_ready", {31'd0, iport_ready}, 32'd0);
        next_cycle();
        rst = 1'b0; mem_ready = 1'b1; mem_data_i = 32'h0BADF00D;
        iport_enable = 1'b1; iport_address = 32'h510;
        dport_enable = 1'b1; dport_address = 32'h600;
        #1;
        chk("rst after mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("rst after iport_ready", {31'd0, iport_ready}, 32'd0);
        chk("rst after iport_error", {31'd0, iport_error}, 32'd0);
        next_cycle();
        #1;
        chk("rst tie mem_address", mem_address, 32'h600);
        chk("rst tie dport_ready", {31'd0, dport_ready}, 32'd1);
        chk("rst tie iport_ready", {31'd0, iport_ready}, 32'd0);
        next_cycle();

        // --- Test 3: fixed priority, both request continuously: dport only
        drive_idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        iport_enable = 1'b1; iport_address = 32'hA0;
        dport_enable = 1'b1; dport_address = 32'hB0;
        fp_dr_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            fp_mem_ready = fp_mem_enable;
            #1;
            chk($sformatf("fp c%0d iport_ready", k), {31'd0, fp_iport_ready}, 32'd0);
            chk($sformatf("fp c%0d iport_error", k), {31'd0, fp_iport_error}, 32'd0);
            if (fp_mem_enable)
                chk($sformatf("fp c%0d mem_address", k), fp_mem_address, 32'hB0);
            if (fp_dport_ready) fp_dr_cnt++;
            next_cycle();
        end
        chk("fp dport_ready count", fp_dr_cnt, 32'd6);
        drive_idle();
        fp_mem_ready = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
